shift_and_subtract_binary_divider: RTL and testbench

Sequential restoring binary divider: the inverse of the team's shift-and-add multiplier. It takes an m-bit unsigned dividend and an n-bit unsigned divisor. It produces one quotient bit per clock, MSB first, using a shift/trial-subtract/restore loop. It sits beside the multiplier in the arithmetic datapath and uses a start/busy/done handshake, so the caller can check products (C / B == A, remainder 0).

---
 rtl/shift_and_subtract_binary_divider_if.sv | 26 ++
 rtl/shift_and_subtract_binary_divider.sv | 114 +++++++++++
 tb/tb_shift_and_subtract_binary_divider.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/shift_and_subtract_binary_divider_if.sv
// Handshake and operand/result bundle for the restoring divider.
interface shift_and_subtract_binary_divider_if #(
    parameter int unsigned m = 8,
    parameter int unsigned n = 8
);
    logic         start;
    logic [m-1:0] A;
    logic [n-1:0] B;
    logic         busy;
    logic         done;
    logic [m-1:0] Q;
    logic [n-1:0] R;
    logic         div_by_zero;

    // Caller side: issues requests, observes results.
    modport master (
        output start, A, B,
        input  busy, done, Q, R, div_by_zero
    );

    // Divider side.
    modport slave (
        input  start, A, B,
        output busy, done, Q, R, div_by_zero
    );
endinterface

// File: rtl/shift_and_subtract_binary_divider.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// The dividend register doubles as the quotient register; each RUN cycle
// shifts a dividend bit out of the top and a quotient bit into the bottom.
module shift_and_subtract_binary_divider #(
    parameter int unsigned m = 8,
    parameter int unsigned n = 8
) (
    input logic                             clk,
    input logic                             rst_n,
    shift_and_subtract_binary_divider_if.slave bus
);
    localparam int unsigned CntW = $clog2(m) + 1;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e          state_q, state_d;
    logic [m-1:0]    dq_q, dq_d;     // dividend shifting out, quotient shifting in
    logic [n-1:0]    dvs_q, dvs_d;   // captured divisor
    logic [n:0]      p_q, p_d;       // partial remainder, one spare bit for the shift
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [m-1:0]    q_q, q_d;
    logic [n-1:0]    r_q, r_d;
    logic            dbz_q, dbz_d;

    logic [n:0]      p_shift;
    logic            q_bit;

    // Next-state: accept/reject in idle, one shift/trial-subtract step in run.
    always_comb begin
        state_d = state_q;
        dq_d    = dq_q;
        dvs_d   = dvs_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;

        p_shift = {p_q[n-1:0], dq_q[m-1]};
        q_bit   = (p_shift >= {1'b0, dvs_q});

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.B == '0) begin
                        q_d    = '1;
                        r_d    = '0;
                        dbz_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        dq_d    = bus.A;
                        dvs_d   = bus.B;
                        p_d     = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        dbz_d   = 1'b0;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                // Restoring step: keep the shifted value when the subtract would go negative.
                p_d   = q_bit ? (p_shift - {1'b0, dvs_q}) : p_shift;
                dq_d  = {dq_q[m-2:0], q_bit};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(m - 1)) begin
                    q_d     = dq_d;
                    r_d     = p_d[n-1:0];
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs; async reset aborts any division in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            dq_q    <= '0;
            dvs_q   <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dq_q    <= dq_d;
            dvs_q   <= dvs_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.Q           = q_q;
    assign bus.R           = r_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_shift_and_subtract_binary_divider.sv
// Directed-vector and randomized check of the restoring divider.
module tb_shift_and_subtract_binary_divider;
    localparam int unsigned M = 8;
    localparam int unsigned N = 8;
    localparam int          TIMEOUT = 40;

    logic clk;
    logic rst_n;

    shift_and_subtract_binary_divider_if #(.m(M), .n(N)) bus ();

    shift_and_subtract_binary_divider #(.m(M), .n(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        int         lat;   // edges after the accepting edge until done is seen
        int         bcnt;  // cycles busy is observed high
    } vec_t;

    vec_t vecs[8];
    int   n_tests;
    int   n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Issue one request for a single cycle and wait (bounded) for done.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         output int lat, output int bcnt);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat  = 0;
        bcnt = 0;
        while (!bus.done && lat < TIMEOUT) begin
            if (bus.busy) bcnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= TIMEOUT) check("done_timeout", 32'(lat), 32'(TIMEOUT - 1));
    endtask

    int lat, bcnt, pulses;
    logic [7:0]  ra, rb, eq, er;
    logic [15:0] prod;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2, 1'b0, 8, 8};
        vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0, 1'b0, 8, 8};
        vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5, 1'b0, 8, 8};
        vecs[3] = '{8'd255, 8'd255, 8'd1,   8'd0, 1'b0, 8, 8};
        vecs[4] = '{8'd0,   8'd13,  8'd0,   8'd0, 1'b0, 8, 8};
        vecs[5] = '{8'd200, 8'd0,   8'd255, 8'd0, 1'b1, 0, 0};
        vecs[6] = '{8'd9,   8'd3,   8'd3,   8'd0, 1'b0, 8, 8};
        vecs[7] = '{8'd77,  8'd11,  8'd7,   8'd0, 1'b0, 8, 8};

        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_done", 32'(bus.done), 0);
        check("reset_q", 32'(bus.Q), 0);
        check("reset_r", 32'(bus.R), 0);
        check("reset_dbz", 32'(bus.div_by_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, lat, bcnt);
            check($sformatf("vec%0d_q", i), 32'(bus.Q), 32'(vecs[i].q));
            check($sformatf("vec%0d_r", i), 32'(bus.R), 32'(vecs[i].r));
            check($sformatf("vec%0d_dbz", i), 32'(bus.div_by_zero), 32'(vecs[i].dbz));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'(vecs[i].bcnt));
            check($sformatf("vec%0d_busy_at_done", i), 32'(bus.busy), 0);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_done_pulse", i), 32'(bus.done), 0);
            check($sformatf("vec%0d_q_hold", i), 32'(bus.Q), 32'(vecs[i].q));
        end

        // Start pulsed during RUN is ignored; exactly one done pulse.
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 8'd100;
        bus.B     = 8'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 8'd50;
        bus.B     = 8'd5;
        @(negedge clk);
        bus.start = 1'b0;
        pulses = 0;
        eq = '0;
        er = '0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                pulses++;
                eq = bus.Q;
                er = bus.R;
            end
        end
        check("ignore_start_pulses", 32'(pulses), 1);
        check("ignore_start_q", 32'(eq), 14);
        check("ignore_start_r", 32'(er), 2);

        // Asynchronous reset mid-run clears outputs without a clock edge.
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 8'd100;
        bus.B     = 8'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_q", 32'(bus.Q), 0);
        check("midrst_r", 32'(bus.R), 0);
        check("midrst_done", 32'(bus.done), 0);
        check("midrst_dbz", 32'(bus.div_by_zero), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) pulses++;
        end
        check("midrst_no_done", 32'(pulses), 0);
        do_op(8'd60, 8'd4, lat, bcnt);
        check("after_rst_q", 32'(bus.Q), 15);
        check("after_rst_r", 32'(bus.R), 0);

        // Back-to-back: start held high, second request presented in the done cycle.
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 8'd77;
        bus.B     = 8'd3;
        @(posedge clk);
        #1;
        lat = 0;
        while (!bus.done && lat < TIMEOUT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("b2b_first_latency", 32'(lat), 8);
        check("b2b_first_q", 32'(bus.Q), 25);
        check("b2b_first_r", 32'(bus.R), 2);
        bus.B = 8'd11;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("b2b_second_busy", 32'(bus.busy), 1);
        lat = 1;
        while (!bus.done && lat < TIMEOUT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("b2b_second_latency", 32'(lat), 9);
        check("b2b_second_q", 32'(bus.Q), 7);
        check("b2b_second_r", 32'(bus.R), 0);

        // Random sweep against a behavioural quotient/remainder.
        for (int i = 0; i < 2000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            do_op(ra, rb, lat, bcnt);
            if (rb == 8'd0) begin
                eq = 8'hFF;
                er = 8'd0;
            end else begin
                eq = ra / rb;
                er = ra % rb;
            end
            check($sformatf("rand%0d_%0d/%0d_q", i, ra, rb), 32'(bus.Q), 32'(eq));
            check($sformatf("rand%0d_%0d/%0d_r", i, ra, rb), 32'(bus.R), 32'(er));
            if (rb != 8'd0) begin
                prod = 16'(bus.Q) * 16'(rb) + 16'(bus.R);
                check($sformatf("rand%0d_identity", i), 32'(prod), 32'(ra));
                check($sformatf("rand%0d_r_lt_b", i), 32'(bus.R < rb), 1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
